// File: rtl/interconn_rr_buffered.sv
// Buffered round-robin crossbar between N MVUs: each source multicasts one word to a
// destination subset, each destination arbitrates fairly into a DEPTH-entry output FIFO.
module interconn_rr_buffered #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     send_to    [N-1:0],
  input  logic             send_en    [N-1:0],
  input  logic [BADDR-1:0] send_addr  [N-1:0],
  input  logic [W-1:0]     send_word  [N-1:0],
  output logic             send_grant [N-1:0],
  output logic [N-1:0]     recv_from  [N-1:0],
  output logic             recv_en    [N-1:0],
  output logic [BADDR-1:0] recv_addr  [N-1:0],
  output logic [W-1:0]     recv_word  [N-1:0],
  input  logic             recv_rdy   [N-1:0]
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(DEPTH);
  localparam int CW = DW + 1;

  logic [N-1:0]     served_r   [N-1:0];
  logic [PW-1:0]    ptr_r      [N-1:0];
  logic [CW-1:0]    count_r    [N-1:0];
  logic [DW-1:0]    wr_ptr_r   [N-1:0];
  logic [DW-1:0]    rd_ptr_r   [N-1:0];
  logic [N-1:0]     mem_from_r [N-1:0][DEPTH-1:0];
  logic [BADDR-1:0] mem_addr_r [N-1:0][DEPTH-1:0];
  logic [W-1:0]     mem_word_r [N-1:0][DEPTH-1:0];

  // rem_s/newly_s are indexed by source; req_s/gnt_s by destination with one bit per source
  logic [N-1:0]     rem_s      [N-1:0];
  logic [N-1:0]     req_s      [N-1:0];
  logic [N-1:0]     gnt_s      [N-1:0];
  logic [N-1:0]     newly_s    [N-1:0];
  logic [PW-1:0]    win_s      [N-1:0];
  logic [N-1:0]     push_s;
  logic [N-1:0]     pop_s;
  logic [N-1:0]     done_s;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ... mod N.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    if (w >= PW'(N - 1)) return '0;
    else return w + PW'(1);
  endfunction

  // Remaining destinations per source and the transposed request matrix
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rem_s[i] = send_to[i] & ~served_r[i];
    end
    for (int j = 0; j < N; j++) begin
      req_s[j] = '0;
      for (int i = 0; i < N; i++) begin
        req_s[j][i] = send_en[i] & rem_s[i][j];
      end
    end
  end

  // Per-destination arbitration; a full FIFO blocks on the registered count alone
  always_comb begin
    for (int j = 0; j < N; j++) begin
      logic [PW:0] pick;
      pick      = rr_pick(req_s[j], ptr_r[j]);
      win_s[j]  = pick[PW-1:0];
      push_s[j] = pick[PW] && (count_r[j] < CW'(DEPTH));
      pop_s[j]  = (count_r[j] != '0) && recv_rdy[j];
      gnt_s[j]  = '0;
      if (push_s[j]) begin
        gnt_s[j][win_s[j]] = 1'b1;
      end else begin
        gnt_s[j] = '0;
      end
    end
  end

  // A source completes once every remaining destination is granted this cycle
  always_comb begin
    for (int i = 0; i < N; i++) begin
      newly_s[i] = '0;
      for (int j = 0; j < N; j++) begin
        newly_s[i][j] = gnt_s[j][i];
      end
      done_s[i]     = send_en[i] && ((rem_s[i] & ~newly_s[i]) == '0);
      send_grant[i] = done_s[i] && !clr;
    end
  end

  // Served masks, arbiter pointers and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        served_r[i] <= '0;
        ptr_r[i]    <= '0;
        count_r[i]  <= '0;
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!send_en[i] || done_s[i]) served_r[i] <= '0;
        else                          served_r[i] <= served_r[i] | newly_s[i];
      end
      for (int j = 0; j < N; j++) begin
        if (push_s[j]) begin
          wr_ptr_r[j] <= wr_ptr_r[j] + DW'(1);
          ptr_r[j]    <= next_ptr(win_s[j]);
        end
        if (pop_s[j]) rd_ptr_r[j] <= rd_ptr_r[j] + DW'(1);
        case ({push_s[j], pop_s[j]})
          2'b10:   count_r[j] <= count_r[j] + CW'(1);
          2'b01:   count_r[j] <= count_r[j] - CW'(1);
          default: count_r[j] <= count_r[j];
        endcase
      end
    end
  end

  // FIFO storage; contents are don't-care until the count says they are valid
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (push_s[j] && !clr) begin
        mem_from_r[j][wr_ptr_r[j]] <= gnt_s[j];
        mem_addr_r[j][wr_ptr_r[j]] <= send_addr[win_s[j]];
        mem_word_r[j][wr_ptr_r[j]] <= send_word[win_s[j]];
      end
    end
  end

  // Head presentation, forced to zero while a FIFO is empty
  always_comb begin
    for (int j = 0; j < N; j++) begin
      recv_en[j] = (count_r[j] != '0);
      if (count_r[j] != '0) begin
        recv_from[j] = mem_from_r[j][rd_ptr_r[j]];
        recv_addr[j] = mem_addr_r[j][rd_ptr_r[j]];
        recv_word[j] = mem_word_r[j][rd_ptr_r[j]];
      end else begin
        recv_from[j] = '0;
        recv_addr[j] = '0;
        recv_word[j] = '0;
      end
    end
  end

endmodule
